// File: rtl/serial_word_tx_if.sv
// serial_word_tx_if
//   Bundles the producer handshake and the serial line toward the downstream
//   SIPO register.
//   Signals (WIDTH = data bits per word):
//     Data_IN    [WIDTH-1:0] parallel word from the producer
//     Data_Valid             Data_IN is valid this cycle
//     Data_Ready             holding buffer empty; word taken on Valid & Ready at the edge
//     Serial_OUT             serial bit to the SIPO Serial_IN
//     Load                   shift enable to the SIPO Load
//     Busy                   transmitter active or holding a queued word
//     Word_Done              1-cycle pulse once the downstream register holds a full word
//   Modports: master = producer/observer side, slave = transmitter side.
interface serial_word_tx_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] Data_IN;
  logic             Data_Valid;
  logic             Data_Ready;
  logic             Serial_OUT;
  logic             Load;
  logic             Busy;
  logic             Word_Done;

  modport master (
    output Data_IN, Data_Valid,
    input  Data_Ready, Serial_OUT, Load, Busy, Word_Done
  );

  modport slave (
    input  Data_IN, Data_Valid,
    output Data_Ready, Serial_OUT, Load, Busy, Word_Done
  );
endinterface

// File: rtl/serial_word_tx.sv
// serial_word_tx
//   Accepts parallel words over a valid/ready handshake into a one-word holding
//   buffer and serializes them onto Serial_OUT with a Load strobe that is high
//   exactly while a bit is presented. Word_Done pulses the cycle after the last
//   Load cycle of a word.
//   Ports:
//     CLK  rising-edge clock
//     RST  synchronous active-high reset
//     bus  serial_word_tx_if.slave (Data_IN/Data_Valid in; Data_Ready, Serial_OUT,
//          Load, Busy, Word_Done out)
//   Parameters: WIDTH (>=2), GAP_CYCLES (idle cycles between words), MSB_FIRST.
//   Build option: define SERIAL_TX_PARITY_EN to append an even-parity bit as an
//   extra Load cycle after the data bits.
module serial_word_tx #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  serial_word_tx_if.slave  bus
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned BCW = $clog2(NBITS + 1);
  localparam int unsigned GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [BCW-1:0] BIT_DATA_LAST = BCW'(WIDTH);
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [GCW-1:0]   gap_cnt;
  logic             serial_out;
  logic             load;
  logic             word_done;
`ifdef SERIAL_TX_PARITY_EN
  logic             parity_bit;
`endif

  logic data_ready;
  logic accept;
  logic done;
  logic start;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready is gated by RST so the producer sees 0 throughout reset and 1 on
  // the first cycle after it; there is no path from Data_Valid.
  assign data_ready = ~buf_full & ~RST;
  assign accept     = bus.Data_Valid & data_ready;

  // bit_cnt counts bits already presented, so it equals NBITS while the last
  // bit is on the line; the next edge closes the word.
  assign done  = (state == ST_SHIFT) && (bit_cnt == BIT_LAST);
  assign start = buf_full &&
                 ((state == ST_IDLE) ||
                  ((state == ST_GAP) && (gap_cnt == GAP_LAST)) ||
                  (done && (GAP_CYCLES == 0)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      buf_data   <= '0;
      buf_full   <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      serial_out <= 1'b0;
      load       <= 1'b0;
      word_done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      word_done <= done;

      // accept and start never coincide: accept needs an empty buffer,
      // start needs a full one.
      if (accept) begin
        buf_data <= bus.Data_IN;
        buf_full <= 1'b1;
      end

      if (start) begin
        // First bit goes straight onto the line; shreg keeps the remainder.
        buf_full   <= 1'b0;
        shreg      <= advance(buf_data);
        serial_out <= head_bit(buf_data);
        load       <= 1'b1;
        bit_cnt    <= BCW'(1);
        gap_cnt    <= '0;
        state      <= ST_SHIFT;
`ifdef SERIAL_TX_PARITY_EN
        parity_bit <= ^buf_data;
`endif
      end else begin
        case (state)
          ST_SHIFT: begin
            if (done) begin
              load       <= 1'b0;
              serial_out <= 1'b0;
              bit_cnt    <= '0;
              gap_cnt    <= '0;
              state      <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
              load    <= 1'b1;
              bit_cnt <= bit_cnt + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
              if (bit_cnt == BIT_DATA_LAST) begin
                serial_out <= parity_bit;
              end else begin
                serial_out <= head_bit(shreg);
                shreg      <= advance(shreg);
              end
`else
              serial_out <= head_bit(shreg);
              shreg      <= advance(shreg);
`endif
            end
          end
          ST_GAP: begin
            load       <= 1'b0;
            serial_out <= 1'b0;
            if (gap_cnt == GAP_LAST) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          ST_IDLE: begin
            load       <= 1'b0;
            serial_out <= 1'b0;
          end
          default: begin
            load       <= 1'b0;
            serial_out <= 1'b0;
            state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.Data_Ready = data_ready;
  assign bus.Serial_OUT = serial_out;
  assign bus.Load       = load;
  assign bus.Word_Done  = word_done;
  assign bus.Busy       = (state != ST_IDLE) | buf_full;

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx
//   Three transmitters share clock and reset:
//     a: GAP_CYCLES=1, MSB_FIRST=1   b: GAP_CYCLES=0, MSB_FIRST=1
//     c: GAP_CYCLES=1, MSB_FIRST=0
//   Expected serial words are queued when a word is accepted and compared
//   when Word_Done is seen. Honours SERIAL_TX_PARITY_EN.
module tb_serial_word_tx;
  localparam int W = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  serial_word_tx_if #(.WIDTH(W)) ia ();
  serial_word_tx_if #(.WIDTH(W)) ib ();
  serial_word_tx_if #(.WIDTH(W)) ic ();

  serial_word_tx #(.WIDTH(W), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) dut_a (.CLK(CLK), .RST(RST), .bus(ia));
  serial_word_tx #(.WIDTH(W), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) dut_b (.CLK(CLK), .RST(RST), .bus(ib));
  serial_word_tx #(.WIDTH(W), .GAP_CYCLES(1), .MSB_FIRST(1'b0)) dut_c (.CLK(CLK), .RST(RST), .bus(ic));

  int tests = 0;
  int fails = 0;

  logic [NB-1:0] q_a[$];
  logic [NB-1:0] q_b[$];
  logic [NB-1:0] q_c[$];
  logic [NB-1:0] coll[3];
  int            cnt[3];

  logic [NB-1:0] sipo_a = '0;
  int            cyc = 0;
  int            run_b = 0;
  int            max_run_b = 0;
  int            wd_cyc_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial order: bit i of the result is the i-th bit on the line.
  function automatic logic [NB-1:0] ser_bits(input logic [W-1:0] d, input bit msb);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = msb ? d[W-1-i] : d[i];
`ifdef SERIAL_TX_PARITY_EN
    r[W] = ^d;
`endif
    return r;
  endfunction

  function automatic bit msb_of(input int d);
    return (d == 2) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic ready_of(input int d);
    case (d)
      0: return ia.Data_Ready;
      1: return ib.Data_Ready;
      default: return ic.Data_Ready;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q_a.size();
      1: return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic push_exp(input int d, input logic [NB-1:0] v);
    case (d)
      0: q_a.push_back(v);
      1: q_b.push_back(v);
      default: q_c.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int d, output logic [NB-1:0] v);
    case (d)
      0: v = q_a.pop_front();
      1: v = q_b.pop_front();
      default: v = q_c.pop_front();
    endcase
  endtask

  task automatic drive(input int d, input logic [W-1:0] data, input logic v);
    case (d)
      0: begin ia.Data_IN = data; ia.Data_Valid = v; end
      1: begin ib.Data_IN = data; ib.Data_Valid = v; end
      default: begin ic.Data_IN = data; ic.Data_Valid = v; end
    endcase
  endtask

  // Returns #1 after the accepting edge; edges = edges waited including it.
  task automatic send(input int d, input logic [W-1:0] data, output int edges);
    logic r;
    edges = 0;
    drive(d, data, 1'b1);
    do begin
      r = ready_of(d);
      @(posedge CLK); #1;
      edges++;
    end while (!r && edges < 100);
    check($sformatf("accepted_%0d", d), r, 1);
    if (r) push_exp(d, ser_bits(data, msb_of(d)));
    drive(d, '0, 1'b0);
  endtask

  task automatic monitor(input int d, input logic ld, input logic so, input logic wd);
    logic [NB-1:0] e;
    if (RST) begin
      cnt[d]  = 0;
      coll[d] = '0;
      return;
    end
    if (!ld) check($sformatf("line_low_idle_%0d", d), so, 0);
    if (wd) begin
      if (qsize(d) == 0) begin
        check($sformatf("unexpected_word_done_%0d", d), wd, 0);
      end else begin
        pop_exp(d, e);
        check($sformatf("word_bits_%0d", d), coll[d], e);
        check($sformatf("word_len_%0d", d), cnt[d], NB);
      end
      cnt[d]  = 0;
      coll[d] = '0;
    end
    if (ld) begin
      if (cnt[d] < NB) coll[d][cnt[d]] = so;
      cnt[d]++;
    end
  endtask

  always @(posedge CLK) if (ia.Load) sipo_a <= {sipo_a[NB-2:0], ia.Serial_OUT};

  always @(negedge CLK) begin
    cyc++;
    monitor(0, ia.Load, ia.Serial_OUT, ia.Word_Done);
    monitor(1, ib.Load, ib.Serial_OUT, ib.Word_Done);
    monitor(2, ic.Load, ic.Serial_OUT, ic.Word_Done);
    if (ib.Load) run_b++;
    else run_b = 0;
    if (run_b > max_run_b) max_run_b = run_b;
    if (ib.Word_Done) wd_cyc_b.push_back(cyc);
  end

  // Full timing check of one word on transmitter a, which must be idle.
  task automatic directed_a(input logic [W-1:0] data);
    logic [NB-1:0] e;
    logic [NB-1:0] sipo_exp;
    int edges;
    e = ser_bits(data, 1'b1);
`ifdef SERIAL_TX_PARITY_EN
    sipo_exp = {data, ^data};
`else
    sipo_exp = data;
`endif
    send(0, data, edges);
    check("a_ready_while_full", ia.Data_Ready, 0);
    check("a_busy", ia.Busy, 1);
    for (int i = 0; i < NB; i++) begin
      @(posedge CLK); #1;
      if (i == 0) check("a_ready_drained", ia.Data_Ready, 1);
      check($sformatf("a_load_bit%0d", i), ia.Load, 1);
      check($sformatf("a_serial_bit%0d", i), ia.Serial_OUT, e[i]);
      check($sformatf("a_done_early%0d", i), ia.Word_Done, 0);
    end
    @(posedge CLK); #1;
    check("a_load_after_word", ia.Load, 0);
    check("a_word_done", ia.Word_Done, 1);
    check("a_sipo_word", sipo_a, sipo_exp);
    @(posedge CLK); #1;
    check("a_word_done_pulse", ia.Word_Done, 0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int e1, e2, e3;
    drive(0, '0, 1'b0);
    drive(1, '0, 1'b0);
    drive(2, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin cnt[i] = 0; coll[i] = '0; end

    // Reset and idle
    RST = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
      check("rst_ready", ia.Data_Ready, 0);
      check("rst_load", ia.Load, 0);
      check("rst_serial", ia.Serial_OUT, 0);
      check("rst_word_done", ia.Word_Done, 0);
      check("rst_busy", ia.Busy, 0);
    end
    RST = 1'b0;
    #1;
    check("ready_after_rst_a", ia.Data_Ready, 1);
    check("ready_after_rst_b", ib.Data_Ready, 1);
    check("ready_after_rst_c", ic.Data_Ready, 1);
    @(posedge CLK); #1;

    // Single word, exact timing
    directed_a(4'b1011);

    // Back-to-back, no gap
    max_run_b = 0;
    wd_cyc_b.delete();
    send(1, 4'b1100, e1);
    check("b_ready_while_full", ib.Data_Ready, 0);
    send(1, 4'b0011, e2);
    repeat (2 * NB + 4) @(posedge CLK);
    #1;
    check("b_load_run", max_run_b, 2 * NB);
    check("b_word_done_count", wd_cyc_b.size(), 2);
    if (wd_cyc_b.size() == 2) check("b_word_done_spacing", wd_cyc_b[1] - wd_cyc_b[0], NB);

    // Backpressure with LSB-first
    send(2, 4'b1011, e1);
    send(2, 4'b0110, e2);
    send(2, 4'b1001, e3);
    check("c_first_accept_edges", e1, 1);
    check("c_second_accept_edges", e2, 2);
    check("c_third_stall_edges", e3, NB + 1);
    repeat (3 * (NB + 1) + 4) @(posedge CLK);
    #1;

    // Reset mid-word
    send(0, 4'b1111, e1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("mid_load", ia.Load, 1);
    check("mid_serial", ia.Serial_OUT, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    q_a.delete();
    q_b.delete();
    q_c.delete();
    check("abort_load", ia.Load, 0);
    check("abort_word_done", ia.Word_Done, 0);
    check("abort_busy", ia.Busy, 0);
    check("abort_ready_in_rst", ia.Data_Ready, 0);
    RST = 1'b0;
    #1;
    check("abort_ready_after", ia.Data_Ready, 1);
    for (int i = 0; i < NB + 3; i++) begin
      @(posedge CLK); #1;
      check($sformatf("abort_no_done%0d", i), ia.Word_Done, 0);
    end
    directed_a(4'b0101);

`ifdef SERIAL_TX_PARITY_EN
    directed_a(4'b0111);
    directed_a(4'b0110);
`endif

    repeat (4) @(posedge CLK);
    #1;
    check("a_queue_drained", qsize(0), 0);
    check("b_queue_drained", qsize(1), 0);
    check("c_queue_drained", qsize(2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
